// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one single-cycle 64-bit ALU between two requesters.
// Operands are registered into the ALU; results return on per-requester valid/ready channels.
module alu_arbiter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_src1,
  input  logic [XLEN-1:0] req0_src2,
  input  logic [1:0]      req0_aluop,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_src1,
  input  logic [XLEN-1:0] req1_src2,
  input  logic [1:0]      req1_aluop,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [XLEN-1:0] rsp0_result,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp1_result,
  output logic [XLEN-1:0] alu_src1,
  output logic [XLEN-1:0] alu_src2,
  output logic [1:0]      alu_aluop,
  input  logic [XLEN-1:0] alu_result,
  output logic            dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // req*_ready is combinational from req*_valid; rsp*_valid never depends on rsp*_ready.
  typedef enum logic {S_IDLE = 1'b0, S_EXEC = 1'b1} state_e;

  state_e          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            grant_id_q, grant_id_d;
  logic [XLEN-1:0] src1_q, src1_d;
  logic [XLEN-1:0] src2_q, src2_d;
  logic [1:0]      aluop_q, aluop_d;
  logic            rsp0_valid_q, rsp0_valid_d;
  logic            rsp1_valid_q, rsp1_valid_d;
  logic [XLEN-1:0] rsp0_result_q, rsp0_result_d;
  logic [XLEN-1:0] rsp1_result_q, rsp1_result_d;

  logic elig0, elig1, grant_any, grant_sel;

  // A requester with an unconsumed response may not issue again.
  assign elig0     = req0_valid && !rsp0_valid_q;
  assign elig1     = req1_valid && !rsp1_valid_q;
  assign grant_any = elig0 || elig1;
  assign grant_sel = (elig0 && elig1) ? !last_grant_q : elig1;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_id_d    = grant_id_q;
    src1_d        = src1_q;
    src2_d        = src2_q;
    aluop_d       = aluop_q;
    rsp0_valid_d  = rsp0_valid_q;
    rsp1_valid_d  = rsp1_valid_q;
    rsp0_result_d = rsp0_result_q;
    rsp1_result_d = rsp1_result_q;
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;

    if (rsp0_valid_q && rsp0_ready) rsp0_valid_d = 1'b0;
    if (rsp1_valid_q && rsp1_ready) rsp1_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          req0_ready   = rst_n && !grant_sel;
          req1_ready   = rst_n && grant_sel;
          src1_d       = grant_sel ? req1_src1  : req0_src1;
          src2_d       = grant_sel ? req1_src2  : req0_src2;
          aluop_d      = grant_sel ? req1_aluop : req0_aluop;
          grant_id_d   = grant_sel;
          last_grant_d = grant_sel;
          state_d      = S_EXEC;
        end
      end
      S_EXEC: begin
        if (grant_id_q) begin
          rsp1_valid_d  = 1'b1;
          rsp1_result_d = alu_result;
        end else begin
          rsp0_valid_d  = 1'b1;
          rsp0_result_d = alu_result;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      last_grant_q  <= 1'b1;
      grant_id_q    <= 1'b0;
      src1_q        <= '0;
      src2_q        <= '0;
      aluop_q       <= 2'b00;
      rsp0_valid_q  <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp0_result_q <= '0;
      rsp1_result_q <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_id_q    <= grant_id_d;
      src1_q        <= src1_d;
      src2_q        <= src2_d;
      aluop_q       <= aluop_d;
      rsp0_valid_q  <= rsp0_valid_d;
      rsp1_valid_q  <= rsp1_valid_d;
      rsp0_result_q <= rsp0_result_d;
      rsp1_result_q <= rsp1_result_d;
    end
  end

  // Operand registers hold their last values in IDLE; only the opcode is masked.
  assign alu_src1    = src1_q;
  assign alu_src2    = src2_q;
  assign alu_aluop   = (state_q == S_EXEC) ? aluop_q : 2'b00;
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp0_result = rsp0_result_q;
  assign rsp1_result = rsp1_result_q;
  assign dbg_state   = (state_q == S_EXEC);

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single-cycle 64-bit integer ALU (add / unsigned set-less-than) between two requesters, e.g. the EXU and the LSU address path. Accepts requests over valid/ready handshakes, arbitrates round-robin, registers operands into the ALU, captures the result, and returns it on a per-requester valid/ready response channel. One operation is in flight at a time.

## Interface

- XLEN, 64, operand and result width

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_src1, req0_src2 / req1_src1, req1_src2  in  XLEN  operands
- req0_aluop / req1_aluop  in  2  bit0 = add, bit1 = sltu (one-hot)
- rsp0_valid / rsp1_valid  out  1  result available
- rsp0_ready / rsp1_ready  in  1  result consumed
- rsp0_result / rsp1_result  out  XLEN  result
- alu_src1, alu_src2  out  XLEN  to ALU
- alu_aluop  out  2  to ALU
- alu_result  in  XLEN  from ALU (combinational)

## Operation

- FSM: IDLE, EXEC. Reset state IDLE.
- Requester i eligible in IDLE iff reqi_valid && !rspi_valid (registered value). No second request from i while its response is pending.
- Round-robin: last_grant register, reset 1 (requester 0 wins first). Both eligible -> grant !last_grant; one eligible -> that one.
- IDLE with a grant: reqi_ready = 1 for the granted requester only (combinational from reqi_valid); latch src1, src2, aluop into operand registers, record grant id, update last_grant, go to EXEC.
- EXEC: operand registers drive alu_*; capture alu_result into rspi_result of the recorded requester, set rspi_valid; return to IDLE.
- rspi_valid holds, with rspi_result stable, until rspi_ready is sampled high; it then clears the next cycle.
- aluop forwarded unchanged, including 2'b00 (result 0) and 2'b11 (ALU returns add | sltu). No checking.
- In IDLE, operand registers keep their last values; alu_aluop is forced to 2'b00.

## Timing

- Reset values: req*_ready 0, rsp*_valid 0, rsp*_result 0, alu_src1/alu_src2 0, alu_aluop 0, last_grant 1, state IDLE.
- Reset asserted mid-EXEC: the operation is dropped, no response is produced, and all state returns to reset values immediately.
- Latency: handshake in cycle N -> rspi_valid high in cycle N+2.
- Throughput: one grant every 2 cycles at most; IDLE always follows EXEC.
- Simultaneous rspi handshake and reqi_valid in IDLE: i is not eligible that cycle (rspi_valid is still 1); earliest grant is the next cycle.
- The other requester may be granted while i holds a pending response; responses are independent.
- req*_ready is 0 in EXEC and in reset.

## Test plan

- Single add: req0 src1=0xFFFF_FFFF_FFFF_FFFF, src2=1, aluop=01 -> req0_ready in cycle N, rsp0_valid in N+2 with rsp0_result=0.
- sltu, unsigned: req1 src1=3, src2=5, aluop=10 -> rsp1_result=1. Then src1=0xFFFF_FFFF_FFFF_FFFF, src2=1 -> rsp1_result=0.
- Contention after reset, both requesting every cycle with responses consumed immediately -> grants 0,1,0,1; each requester's results match its own operands.
- Back-pressure: rsp0_ready=0 for 5 cycles with req0 asserted -> rsp0_valid and rsp0_result stay stable and req0 gets no new grant; req1 is still served. After rsp0_ready=1, req0 is granted on the cycle after the handshake.
- Reset mid-EXEC: drop rst_n during EXEC -> all outputs 0 asynchronously; after release, no rsp*_valid appears, and the next grant goes to requester 0.
- aluop 00 and 11: src1=4, src2=9 -> results 0 and 13|1=13 respectively.
